seq_multiplier: RTL and testbench

Parametrised sequential radix-2 shift-add multiplier. It is the clocked successor to the 4-bit combinational multiplier in the ALU.
- Generalised to WIDTH-bit operands.
- Adds a signed (two's complement) mode.
- Uses a start/busy/done handshake.
- Splits the 2*WIDTH-bit result into product_low and product_high, matching the existing ALU output convention.
- Sits in the ALU multiply path; the ALU controller issues start and waits for done.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/seq_multiplier_mag_conv.sv | 17 +
 rtl/seq_multiplier.sv | 107 ++++++++++
 tb/tb_seq_multiplier.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and
// a two's-complement negate usable at any width up to MAX_W bits.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest value the negate helper handles: a 2*32-bit product.
  localparam int MAX_W = 64;

  // Callers zero-extend into MAX_W bits and cast the result back down; the
  // low bits of a wide negate equal the narrow negate.
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/seq_multiplier_mag_conv.sv
// Operand magnitude/sign split: for signed operands with MSB set, returns the
// two's negate as an unsigned WIDTH-bit magnitude (most-negative maps exactly).
module mag_conv
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  assign sign = signed_mode & value[WIDTH-1];
  assign mag  = sign ? WIDTH'(twos_neg(MAX_W'(value))) : value;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier with start/busy/done handshake; signed mode
// multiplies magnitudes and negates the finished product when signs differ.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_low,
  output logic [WIDTH-1:0] product_high
);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] final_prod;
  logic               last_step;

  mag_conv #(.WIDTH(WIDTH)) u_mag_a (
    .value       (A),
    .signed_mode (signed_mode),
    .mag         (mag_a),
    .sign        (sign_a)
  );

  mag_conv #(.WIDTH(WIDTH)) u_mag_b (
    .value       (B),
    .signed_mode (signed_mode),
    .mag         (mag_b),
    .sign        (sign_b)
  );

  // One iteration: conditional add into the upper half (carry kept in
  // sum[WIDTH]), then the whole {acc, mplier} register shifts right by one.
  assign sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
  assign shifted    = {sum, mplier[WIDTH-1:1]};
  assign final_prod = neg ? (2*WIDTH)'(twos_neg(MAX_W'(shifted))) : shifted;
  assign last_step  = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: every register here uses non-blocking assignment so all updates in
  // a clock edge see the pre-edge values, matching the hardware flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      product_low  <= '0;
      product_high <= '0;
      mcand        <= '0;
      acc          <= '0;
      mplier       <= '0;
      cnt          <= '0;
      neg          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= ST_RUN;
            busy   <= 1'b1;
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= sign_a ^ sign_b;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            product_low  <= final_prod[WIDTH-1:0];
            product_high <= final_prod[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: a 4-bit and an 8-bit multiplier run against an
// arithmetic reference model, plus directed vectors with literal results.
module tb_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] sm = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] busy, done;
  logic [3:0] pl4, ph4;
  logic [7:0] pl8, ph8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .start (start[0]), .signed_mode (sm[0]),
    .A (a4), .B (b4), .busy (busy[0]), .done (done[0]),
    .product_low (pl4), .product_high (ph4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .start (start[1]), .signed_mode (sm[1]),
    .A (a8), .B (b8), .busy (busy[1]), .done (done[1]),
    .product_low (pl8), .product_high (ph8)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int width_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic logic [7:0] in_a(input int i);
    return (i == 0) ? {4'h0, a4} : a8;
  endfunction

  function automatic logic [7:0] in_b(input int i);
    return (i == 0) ? {4'h0, b4} : b8;
  endfunction

  function automatic logic [15:0] prod_of(input int i);
    return (i == 0) ? {8'h00, ph4, pl4} : {ph8, pl8};
  endfunction

  // Reference product: interpret operands as signed or unsigned integers and
  // multiply, keeping the low 2*w bits.
  function automatic logic [15:0] ref_mul(input int w, input logic s,
                                          input logic [7:0] a, input logic [7:0] b);
    longint mask, av, bv, p;
    mask = (longint'(1) << w) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (s && av[w-1]) av = av - (longint'(1) << w);
    if (s && bv[w-1]) bv = bv - (longint'(1) << w);
    p = (av * bv) & ((longint'(1) << (2 * w)) - 1);
    return 16'(p);
  endfunction

  // Handshake model: an accepted start keeps the unit busy for w cycles,
  // then done pulses once and the product appears.
  int          run_left [2];
  logic        exp_done [2];
  logic [15:0] exp_prod [2];
  logic [15:0] pending  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        run_left[i] <= 0;
        exp_done[i] <= 1'b0;
        exp_prod[i] <= '0;
        pending[i]  <= '0;
      end else begin
        exp_done[i] <= 1'b0;
        if (run_left[i] > 0) begin
          run_left[i] <= run_left[i] - 1;
          if (run_left[i] == 1) begin
            exp_done[i] <= 1'b1;
            exp_prod[i] <= pending[i];
          end
        end else if (start[i]) begin
          run_left[i] <= width_of(i);
          pending[i]  <= ref_mul(width_of(i), sm[i], in_a(i), in_b(i));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy%0d", i), 16'(busy[i]), 16'(run_left[i] > 0));
      check($sformatf("done%0d", i), 16'(done[i]), 16'(exp_done[i]));
      check($sformatf("prod%0d", i), prod_of(i), exp_prod[i]);
    end
  end

  // Called at a falling edge; start is held across exactly one rising edge.
  task automatic issue(input int i, input logic s, input logic [7:0] a, input logic [7:0] b);
    #1;
    if (i == 0) begin
      a4 = a[3:0];
      b4 = b[3:0];
    end else begin
      a8 = a;
      b8 = b;
    end
    sm[i]    = s;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  // Counts falling edges from the accepting rising edge until done is seen.
  task automatic wait_done(input int i, input int cyc0, input logic [15:0] exp, input string name);
    int cyc;
    bit seen;
    cyc  = cyc0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done[i]) seen = 1'b1;
    end
    check({name, "_done_seen"}, 16'(seen), 16'd1);
    if (seen) begin
      check({name, "_latency"}, 16'(cyc), 16'(width_of(i) + 1));
      check({name, "_product"}, prod_of(i), exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_done", 16'(done), 16'd0);
    check("reset_prod4", prod_of(0), 16'h0000);
    check("reset_prod8", prod_of(1), 16'h0000);
    #1 rst_n = 1'b1;

    @(negedge clk); issue(0, 1'b0, 8'h2, 8'h3); wait_done(0, 0, 16'h0006, "t1");

    @(negedge clk); issue(0, 1'b0, 8'hF, 8'hF); wait_done(0, 0, 16'h00E1, "t2a");
    issue(0, 1'b0, 8'h9, 8'h4); wait_done(0, 0, 16'h0024, "t2b");

    @(negedge clk); issue(0, 1'b1, 8'hD, 8'h5); wait_done(0, 0, 16'h00F1, "t3_neg15");
    @(negedge clk); issue(0, 1'b1, 8'h8, 8'h8); wait_done(0, 0, 16'h0040, "t3_minmin");
    @(negedge clk); issue(0, 1'b1, 8'h0, 8'h9); wait_done(0, 0, 16'h0000, "t3_zero");

    @(negedge clk); issue(0, 1'b0, 8'h5, 8'h5);
    @(negedge clk);
    @(negedge clk);
    #1 start[0] = 1'b1; a4 = 4'hF;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 2, 16'h0019, "t4");
    repeat (6) @(negedge clk);

    @(negedge clk); issue(0, 1'b0, 8'h6, 8'h3);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_busy", 16'(busy[0]), 16'd0);
    check("t5_async_done", 16'(done[0]), 16'd0);
    check("t5_async_prod", prod_of(0), 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(0, 1'b0, 8'h6, 8'h3); wait_done(0, 0, 16'h0012, "t5_fresh");

    @(negedge clk); issue(1, 1'b0, 8'hFF, 8'hFF); wait_done(1, 0, 16'hFE01, "t6_ff");
    @(negedge clk); issue(1, 1'b1, 8'h80, 8'h7F); wait_done(1, 0, 16'hC080, "t6_signed");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
